// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the CPU control FSM and its instruction decoder.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_WAIT, S_DECODE, S_MOV_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE, S_ADDR,
    S_LD_ADDR, S_MEM_RD, S_LD_WB, S_ST_C, S_MEM_WR, S_HALT, S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_t;

  typedef enum logic [1:0] {
    VSEL_C     = 2'b00,
    VSEL_PC    = 2'b01,
    VSEL_IMM8  = 2'b10,
    VSEL_MDATA = 2'b11
  } vsel_t;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  typedef enum logic [3:0] {
    K_ILLEGAL, K_MOV_IMM, K_MOV_REG, K_MVN, K_ALU, K_CMP, K_LDR, K_STR, K_HALT
  } kind_t;

  // Collapses opcode/op into the handful of sequences the FSM distinguishes.
  function automatic kind_t classify(input logic [2:0] opcode, input logic [1:0] op);
    kind_t k;
    k = K_ILLEGAL;
    case ({opcode, op})
      {OPC_MOV, OP_MOV_IMM}: k = K_MOV_IMM;
      {OPC_MOV, OP_MOV_REG}: k = K_MOV_REG;
      {OPC_ALU, OP_MVN}:     k = K_MVN;
      {OPC_ALU, OP_ADD},
      {OPC_ALU, OP_AND}:     k = K_ALU;
      {OPC_ALU, OP_CMP}:     k = K_CMP;
      {OPC_LDR, 2'b00}:      k = K_LDR;
      {OPC_STR, 2'b00}:      k = K_STR;
      {OPC_HALT, 2'b00}:     k = K_HALT;
      default:               k = K_ILLEGAL;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction-register field splitter and immediate sign-extender.
module instr_decoder (
  input  logic [15:0] ir_i,
  output logic [2:0]  opcode_o,
  output logic [1:0]  op_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [1:0]  sh_o,
  output logic [2:0]  rm_o,
  output logic [15:0] sximm5_o,
  output logic [15:0] sximm8_o
);

  assign opcode_o = ir_i[15:13];
  assign op_o     = ir_i[12:11];
  assign rn_o     = ir_i[10:8];
  assign rd_o     = ir_i[7:5];
  assign sh_o     = ir_i[4:3];
  assign rm_o     = ir_i[2:0];
  assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};
  assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};

endmodule

// File: rtl/cpu_controller.sv
// Instruction register and Moore control FSM for the 16-bit datapath.
// Define CTRL_ILLEGAL_TRAP_EN to trap undefined encodings instead of treating them as NOPs.
module cpu_controller
  import ctrl_pkg::*;
#(
  parameter int MEM_RD_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic        load_addr,
  output logic [1:0]  mem_cmd,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic        illegal,
`endif
  output logic        halted
);

  localparam logic [2:0] RD_CNT_INIT = 3'(MEM_RD_WAIT - 1);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [2:0]  rd_cnt_q, rd_cnt_d;
  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, sh;
  logic        ready_s;
  kind_t       kind;

  instr_decoder u_decoder (
    .ir_i    (ir_q),
    .opcode_o(opcode),
    .op_o    (op),
    .rn_o    (rn),
    .rd_o    (rd),
    .sh_o    (sh),
    .rm_o    (rm),
    .sximm5_o(sximm5),
    .sximm8_o(sximm8)
  );

  assign kind = classify(opcode, op);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q  <= S_WAIT;
      ir_q     <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d   = state_q;
    ir_d      = ir_q;
    rd_cnt_d  = rd_cnt_q;
    ready_s   = 1'b0;
    readnum   = '0;
    writenum  = '0;
    write     = 1'b0;
    vsel      = VSEL_C;
    loada     = 1'b0;
    loadb     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    shift     = 2'b00;
    ALUop     = 2'b00;
    load_addr = 1'b0;
    mem_cmd   = MEM_NONE;
    halted    = 1'b0;

    unique case (state_q)
      S_WAIT: begin
        ready_s = 1'b1;
        if (instr_valid) begin
          ir_d    = instr_in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (kind)
          K_MOV_IMM:                      state_d = S_MOV_IMM;
          K_MOV_REG, K_MVN:               state_d = S_GET_B;
          K_ALU, K_CMP, K_LDR, K_STR:     state_d = S_GET_A;
          K_HALT:                         state_d = S_HALT;
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_WAIT;
`endif
          end
        endcase
      end
      S_MOV_IMM: begin
        writenum = rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = (kind == K_LDR || kind == K_STR) ? S_ADDR : S_GET_B;
      end
      S_GET_B: begin
        // STR reuses GET_B to fetch the store data from Rd rather than Rm.
        readnum = (kind == K_STR) ? rd : rm;
        loadb   = 1'b1;
        state_d = (kind == K_STR) ? S_ST_C : S_ALU;
      end
      S_ALU: begin
        asel    = (kind == K_MOV_REG);
        shift   = sh;
        ALUop   = op;
        loadc   = (kind != K_CMP);
        loads   = (kind == K_CMP);
        state_d = (kind == K_CMP) ? S_WAIT : S_WRITE;
      end
      S_WRITE: begin
        writenum = rd;
        vsel     = VSEL_C;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_ADDR: begin
        bsel    = 1'b1;
        loadc   = 1'b1;
        state_d = S_LD_ADDR;
      end
      S_LD_ADDR: begin
        load_addr = 1'b1;
        if (kind == K_LDR) begin
          rd_cnt_d = RD_CNT_INIT;
          state_d  = S_MEM_RD;
        end else begin
          state_d  = S_GET_B;
        end
      end
      S_MEM_RD: begin
        mem_cmd = MEM_READ;
        if (rd_cnt_q == 3'd0) state_d = S_LD_WB;
        else                  rd_cnt_d = rd_cnt_q - 3'd1;
      end
      S_LD_WB: begin
        writenum = rd;
        vsel     = VSEL_MDATA;
        write    = 1'b1;
        mem_cmd  = MEM_READ;
        state_d  = S_WAIT;
      end
      S_ST_C: begin
        asel    = 1'b1;
        loadc   = 1'b1;
        state_d = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_cmd = MEM_WRITE;
        state_d = S_WAIT;
      end
      S_HALT:  halted  = 1'b1;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_WAIT;
    endcase
  end

  // Gating with rst_n keeps the handshake closed for the whole reset pulse.
  assign instr_ready = ready_s & rst_n;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_TRAP);
`endif

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed table, corner sequences and random instructions.
module tb_cpu_controller;

  localparam int RD_WAIT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] instr_in = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, asel, bsel, loadc, loads, load_addr, halted;
  logic [1:0]  vsel, shift, ALUop, mem_cmd;
  logic [15:0] sximm5, sximm8;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  typedef struct packed {
    logic       ready;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic [1:0] shift;
    logic [1:0] aluop;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic       halted;
  } outs_t;

  typedef struct {
    string       name;
    logic [15:0] ir;
    int          cycles;
    logic [15:0] sx5;
    logic [15:0] sx8;
  } vec_t;

  cpu_controller #(.MEM_RD_WAIT(RD_WAIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_in   (instr_in),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .readnum    (readnum),
    .writenum   (writenum),
    .write      (write),
    .vsel       (vsel),
    .loada      (loada),
    .loadb      (loadb),
    .asel       (asel),
    .bsel       (bsel),
    .loadc      (loadc),
    .loads      (loads),
    .shift      (shift),
    .ALUop      (ALUop),
    .sximm5     (sximm5),
    .sximm8     (sximm8),
    .load_addr  (load_addr),
    .mem_cmd    (mem_cmd),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal    (illegal),
`endif
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  outs_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic outs_t get_outs();
    outs_t o;
    o.ready     = instr_ready;
    o.readnum   = readnum;
    o.writenum  = writenum;
    o.write     = write;
    o.vsel      = vsel;
    o.loada     = loada;
    o.loadb     = loadb;
    o.asel      = asel;
    o.bsel      = bsel;
    o.loadc     = loadc;
    o.loads     = loads;
    o.shift     = shift;
    o.aluop     = ALUop;
    o.load_addr = load_addr;
    o.mem_cmd   = mem_cmd;
    o.halted    = halted;
    return o;
  endfunction

  function automatic outs_t idle_outs();
    outs_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  // Reference model: the per-cycle output list of one instruction, from DECODE back to WAIT.
  task automatic model_seq(input logic [15:0] ir);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    outs_t      s;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
    rd  = ir[7:5];   sh = ir[4:3];   rm = ir[2:0];
    exp_q.delete();
    exp_q.push_back('0);
    if ({opc, op} == 5'b110_10) begin
      s = '0; s.writenum = rn; s.vsel = 2'b10; s.write = 1'b1; exp_q.push_back(s);
    end else if ({opc, op} == 5'b110_00 || {opc, op} == 5'b101_11) begin
      s = '0; s.readnum = rm; s.loadb = 1'b1; exp_q.push_back(s);
      s = '0; s.loadc = 1'b1; s.shift = sh;
      s.asel  = (opc == 3'b110);
      s.aluop = (opc == 3'b110) ? 2'b00 : 2'b11;
      exp_q.push_back(s);
      s = '0; s.writenum = rd; s.write = 1'b1; exp_q.push_back(s);
    end else if (opc == 3'b101) begin
      s = '0; s.readnum = rn; s.loada = 1'b1; exp_q.push_back(s);
      s = '0; s.readnum = rm; s.loadb = 1'b1; exp_q.push_back(s);
      s = '0; s.aluop = op; s.shift = sh;
      if (op == 2'b01) s.loads = 1'b1; else s.loadc = 1'b1;
      exp_q.push_back(s);
      if (op != 2'b01) begin
        s = '0; s.writenum = rd; s.write = 1'b1; exp_q.push_back(s);
      end
    end else if ({opc, op} == 5'b011_00 || {opc, op} == 5'b100_00) begin
      s = '0; s.readnum = rn; s.loada = 1'b1; exp_q.push_back(s);
      s = '0; s.bsel = 1'b1; s.loadc = 1'b1; exp_q.push_back(s);
      s = '0; s.load_addr = 1'b1; exp_q.push_back(s);
      if (opc == 3'b011) begin
        s = '0; s.mem_cmd = 2'b01;
        for (int k = 0; k < RD_WAIT; k++) exp_q.push_back(s);
        s = '0; s.writenum = rd; s.vsel = 2'b11; s.write = 1'b1; s.mem_cmd = 2'b01;
        exp_q.push_back(s);
      end else begin
        s = '0; s.readnum = rd; s.loadb = 1'b1; exp_q.push_back(s);
        s = '0; s.asel = 1'b1; s.loadc = 1'b1; exp_q.push_back(s);
        s = '0; s.mem_cmd = 2'b10; exp_q.push_back(s);
      end
    end else if ({opc, op} == 5'b111_00) begin
      s = '0; s.halted = 1'b1; exp_q.push_back(s);
      return;
    end
    exp_q.push_back(idle_outs());
  endtask

  // Entered and left at posedge+1 in WAIT; garbage is offered on the handshake while busy.
  task automatic run_instr(input logic [15:0] ir, input string name,
                           output int cycles, output logic [15:0] sx5, output logic [15:0] sx8);
    int last;
    model_seq(ir);
    last   = exp_q.size() - 1;
    cycles = -1;
    sx5    = '0;
    sx8    = '0;
    check({name, "_pre"}, 32'(get_outs()), 32'(idle_outs()));
    instr_in    = ir;
    instr_valid = 1'b1;
    for (int i = 0; i <= last; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        sx5 = sximm5;
        sx8 = sximm8;
      end
      check($sformatf("%s_step%0d", name, i), 32'(get_outs()), 32'(exp_q[i]));
      if (cycles < 0 && instr_ready) cycles = i + 1;
      if (i == last) begin
        instr_valid = 1'b0;
      end else begin
        instr_valid = 1'($urandom);
        instr_in    = 16'($urandom);
      end
    end
  endtask

  vec_t        tbl[10];
  int          cyc;
  logic [15:0] sx5, sx8, ir;
  outs_t       halt_o;

  initial begin
    tbl[0] = '{"mov_imm",  16'hD0FD, 3, 16'hFFFD, 16'hFFFD};
    tbl[1] = '{"add_lsl",  16'hA148, 6, 16'h0008, 16'h0048};
    tbl[2] = '{"cmp",      16'hA900, 5, 16'h0000, 16'h0000};
    tbl[3] = '{"ldr",      16'h617F, 8, 16'hFFFF, 16'h007F};
    tbl[4] = '{"str",      16'h8144, 8, 16'h0004, 16'h0044};
    tbl[5] = '{"mvn",      16'hB822, 5, 16'h0002, 16'h0022};
    tbl[6] = '{"mov_reg",  16'hC0F3, 5, 16'hFFF3, 16'hFFF3};
    tbl[7] = '{"and",      16'hB3E5, 6, 16'h0005, 16'hFFE5};
    tbl[8] = '{"nop_zero", 16'h0000, 2, 16'h0000, 16'h0000};
    tbl[9] = '{"nop_c8",   16'hC8AA, 2, 16'h000A, 16'hFFAA};

    #1 rst_n = 1'b0;
    #1 check("reset_async", 32'(get_outs()), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    check("reset_held", 32'(get_outs()), 32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_release", 32'(get_outs()), 32'(idle_outs()));

    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i].ir, tbl[i].name, cyc, sx5, sx8);
      check({tbl[i].name, "_cycles"}, 32'(cyc), 32'(tbl[i].cycles));
      check({tbl[i].name, "_sximm5"}, 32'(sx5), 32'(tbl[i].sx5));
      check({tbl[i].name, "_sximm8"}, 32'(sx8), 32'(tbl[i].sx8));
    end

    // Reset landing in MEM_RD must drop the read command without waiting for a clock.
    instr_in    = 16'h617F;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("ldr_in_mem_rd", 32'(mem_cmd), 32'h1);
    #1 rst_n = 1'b0;
    #1 check("abort_mem_rd", 32'(get_outs()), 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_recover", 32'(get_outs()), 32'(idle_outs()));

    run_instr(16'hE000, "halt", cyc, sx5, sx8);
    halt_o = '0;
    halt_o.halted = 1'b1;
    for (int i = 0; i < 12; i++) begin
      instr_valid = 1'b1;
      instr_in    = 16'hD0FD;
      @(posedge clk); #1;
      check($sformatf("halt_hold%0d", i), 32'(get_outs()), 32'(halt_o));
    end
    instr_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("halt_reset", 32'(get_outs()), 32'h0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("halt_recover", 32'(get_outs()), 32'(idle_outs()));

    for (int k = 0; k < 60; k++) begin
      ir = 16'($urandom);
      case ($urandom_range(0, 8))
        0: ir[15:11] = 5'b110_10;
        1: ir[15:11] = 5'b110_00;
        2: ir[15:11] = 5'b101_11;
        3: ir[15:11] = 5'b101_00;
        4: ir[15:11] = 5'b101_10;
        5: ir[15:11] = 5'b101_01;
        6: ir[15:11] = 5'b011_00;
        7: ir[15:11] = 5'b100_00;
        default: ;
      endcase
      if (ir[15:11] == 5'b111_00) ir[11] = 1'b1;
      run_instr(ir, $sformatf("rand%0d_%h", k, ir), cyc, sx5, sx8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
